cpuclk_ctrl: RTL and testbench

Lock-qualified clock-enable and reset sequencer that sits directly behind the `cpuclk` PLL and replaces the gated `pll_clk & locked` clock. It synchronises and filters the PLL lock, then sequences the CPU reset. It generates NCH glitch-free clock-enable channels with programmable dividers. Channel 0 drives the CPU and supports run, halt and single-step modes for board-level debug.

---
 rtl/cpuclk_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_cpuclk_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/cpuclk_ctrl.sv
// Lock-qualified clock-enable and CPU reset sequencer for the cpuclk PLL domain.
// Filters PLL lock, sequences cpu_rst, and emits NCH divided clock-enable channels.
module cpuclk_ctrl #(
    parameter int NCH       = 2,
    parameter int DIV_W     = 8,
    parameter int LOCK_FILT = 16,
    parameter int RST_HOLD  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 locked,
    input  logic [NCH*DIV_W-1:0] div,
    input  logic [1:0]           mode,
    input  logic                 step,
    input  logic                 clr_lost,
    output logic [NCH-1:0]       ce,
    output logic                 cpu_rst,
    output logic                 ready,
    output logic                 lock_lost
);

    localparam logic [1:0] S_WAIT = 2'd0;
    localparam logic [1:0] S_FILT = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [1:0] S_RUN  = 2'd3;

    localparam logic [1:0] M_HALT = 2'b01;
    localparam logic [1:0] M_STEP = 2'b10;

    localparam int FW = (LOCK_FILT > 1) ? $clog2(LOCK_FILT) : 1;
    localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [FW-1:0]    LF_LAST = FW'(LOCK_FILT - 1);
    localparam logic [HW-1:0]    HD_LAST = HW'(RST_HOLD - 1);
    localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

    // A zero divisor behaves as divide-by-one.
    function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] d);
        return (d == '0) ? DIV_ONE : d;
    endfunction

    logic             lock_p0, ls;
    logic [1:0]       state, state_n;
    logic [FW-1:0]    fcnt, fcnt_n, fcnt_inc;
    logic [HW-1:0]    hcnt, hcnt_n;
    logic             lost_set;
    logic             active, active_n;
    logic [DIV_W-1:0] cnt   [NCH];
    logic [DIV_W-1:0] cnt_n [NCH];
    logic [DIV_W-1:0] dreg  [NCH];
    logic [DIV_W-1:0] d_n   [NCH];
    logic [NCH-1:0]   tick_n, ce_n;
    logic             step_q, step_edge, pend, pend_n;

    assign fcnt_inc  = fcnt + 1'b1;
    assign active    = (state == S_HOLD) || (state == S_RUN);
    assign active_n  = (state_n == S_HOLD) || (state_n == S_RUN);
    assign step_edge = step & ~step_q;

    // Sequencer; the filter counts the WAIT_LOCK sample as the first locked cycle.
    always_comb begin
        state_n  = state;
        fcnt_n   = fcnt;
        hcnt_n   = hcnt;
        lost_set = 1'b0;
        case (state)
            S_WAIT: begin
                if (ls) begin
                    state_n = (LOCK_FILT > 1) ? S_FILT : S_HOLD;
                    fcnt_n  = '0;
                    hcnt_n  = '0;
                end
            end
            S_FILT: begin
                if (!ls) begin
                    state_n = S_WAIT;
                end else if (fcnt_inc == LF_LAST) begin
                    state_n = S_HOLD;
                    hcnt_n  = '0;
                end else begin
                    fcnt_n = fcnt_inc;
                end
            end
            S_HOLD: begin
                if (!ls) begin
                    state_n = S_WAIT;
                end else if (hcnt == HD_LAST) begin
                    state_n = S_RUN;
                end else begin
                    hcnt_n = hcnt + 1'b1;
                end
            end
            S_RUN: begin
                if (!ls) begin
                    state_n  = S_WAIT;
                    lost_set = 1'b1;
                end
            end
            default: state_n = S_WAIT;
        endcase
    end

    // Divider channels: the divisor is only re-latched at a wrap or on entry to HOLD.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            cnt_n[i]  = '0;
            d_n[i]    = dreg[i];
            if (active_n) begin
                if (!active) begin
                    d_n[i] = eff_div(div[i*DIV_W +: DIV_W]);
                end else if (cnt[i] == dreg[i] - DIV_ONE) begin
                    d_n[i] = eff_div(div[i*DIV_W +: DIV_W]);
                end else begin
                    cnt_n[i] = cnt[i] + DIV_ONE;
                end
            end
            tick_n[i] = active_n && (cnt_n[i] == d_n[i] - DIV_ONE);
        end
    end

    // Channel-0 debug gating; a consuming tick takes priority over a new step edge.
    always_comb begin
        ce_n   = tick_n;
        pend_n = pend;
        if (state_n != S_RUN || mode != M_STEP) begin
            pend_n = 1'b0;
        end else if (pend && tick_n[0]) begin
            pend_n = 1'b0;
        end else if (step_edge) begin
            pend_n = 1'b1;
        end
        if (state_n == S_RUN) begin
            if (mode == M_HALT) begin
                ce_n[0] = 1'b0;
            end else if (mode == M_STEP) begin
                ce_n[0] = tick_n[0] & pend;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_p0   <= 1'b0;
            ls        <= 1'b0;
            state     <= S_WAIT;
            fcnt      <= '0;
            hcnt      <= '0;
            step_q    <= 1'b0;
            pend      <= 1'b0;
            ce        <= '0;
            cpu_rst   <= 1'b1;
            ready     <= 1'b0;
            lock_lost <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            lock_p0   <= locked;
            ls        <= lock_p0;
            state     <= state_n;
            fcnt      <= fcnt_n;
            hcnt      <= hcnt_n;
            step_q    <= step;
            pend      <= pend_n;
            ce        <= ce_n;
            cpu_rst   <= (state_n != S_RUN);
            ready     <= (state_n == S_RUN);
            lock_lost <= lost_set | (lock_lost & ~clr_lost);
            for (int i = 0; i < NCH; i++) begin
                cnt[i] <= cnt_n[i];
            end
        end
    end

    // Latched divisors are reloaded before every use, so they carry no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            dreg[i] <= d_n[i];
        end
    end

endmodule

// File: tb/tb_cpuclk_ctrl.sv
// Self-checking bench for cpuclk_ctrl: lock sequencing, dividers, step/halt debug, loss and reset.
module tb_cpuclk_ctrl;

    localparam int NCH   = 2;
    localparam int DIV_W = 8;
    localparam int NVEC  = 95;

    localparam logic [4:0] M_ALL = 5'b11111;
    localparam logic [4:0] M_CTL = 5'b00111;
    localparam logic [4:0] M_LL  = 5'b00001;

    logic                 clk = 1'b0;
    logic                 rst, locked, step, clr_lost;
    logic [1:0]           mode;
    logic [NCH*DIV_W-1:0] div;
    logic [NCH-1:0]       ce;
    logic                 cpu_rst, ready, lock_lost;

    cpuclk_ctrl #(.NCH(NCH), .DIV_W(DIV_W), .LOCK_FILT(16), .RST_HOLD(8)) dut (
        .clk(clk), .rst(rst), .locked(locked), .div(div), .mode(mode), .step(step),
        .clr_lost(clr_lost), .ce(ce), .cpu_rst(cpu_rst), .ready(ready), .lock_lost(lock_lost)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] mode;
        logic       step;
        logic       ce0;
        logic       ce1;
    } vec_t;

    typedef struct {
        string      name;
        logic [4:0] val;
        logic [4:0] mask;
    } exp_t;

    vec_t tbl [NVEC];
    exp_t sbq [$];
    int   checks   = 0;
    int   failures = 0;

    function automatic logic [4:0] outs();
        return {ce[1], ce[0], cpu_rst, ready, lock_lost};
    endfunction

    task automatic chk(input string name, input logic [4:0] act, input logic [4:0] req,
                       input logic [4:0] mask);
        checks++;
        if ((act & mask) !== (req & mask)) begin
            failures++;
            $display("FAIL %s: got {ce1,ce0,cpu_rst,ready,lock_lost}=%b want %b (mask %b) t=%0t",
                     name, act, req, mask, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask

    // Expectation is queued when the stimulus is applied and retired one edge later.
    task automatic cyc(input string name, input logic [4:0] val, input logic [4:0] mask);
        exp_t e;
        e.name = name;
        e.val  = val;
        e.mask = mask;
        sbq.push_back(e);
        @(posedge clk);
        @(negedge clk);
        e = sbq.pop_front();
        chk(e.name, outs(), e.val, e.mask);
    endtask

    task automatic measure_ready(output int n);
        n = 0;
        while (n < 200) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (ready) break;
        end
    endtask

    initial begin
        int n;
        logic ce0_e, ce1_e;

        // Cycle c = 41+j; cnt1 phase started at cycle 18, channel-0 ticks land on c%3==1.
        for (int j = 0; j < NVEC; j++) begin
            int c;
            c = 41 + j;
            tbl[j].mode = (c < 86) ? 2'b10 : 2'b01;
            tbl[j].step = (c == 44) || (c == 56) || (c == 68) || (c == 74) || (c == 76);
            tbl[j].ce0  = (c == 46) || (c == 58) || (c == 70) || (c == 76);
            tbl[j].ce1  = ((c - 18) % 4) == 3;
        end

        rst      = 1'b1;
        locked   = 1'b1;
        div      = {8'd4, 8'd1};
        mode     = 2'b00;
        step     = 1'b0;
        clr_lost = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_state", outs(), 5'b00100, M_ALL);
        rst = 1'b0;

        // Power-up: HOLD from edge 18, RUN from edge 26.
        for (int k = 1; k <= 40; k++) begin
            ce0_e = (k >= 18);
            ce1_e = (k >= 18) && (((k - 18) % 4) == 3);
            cyc("powerup", {ce1_e, ce0_e, (k < 26), (k >= 26), 1'b0}, M_ALL);
        end

        div[7:0] = 8'd3;
        for (int j = 0; j < NVEC; j++) begin
            mode = tbl[j].mode;
            step = tbl[j].step;
            cyc("step_table", {tbl[j].ce1, tbl[j].ce0, 1'b0, 1'b1, 1'b0}, M_ALL);
        end

        // cnt1 is 1 here; the old period of 4 finishes before the period of 2 starts.
        mode      = 2'b00;
        step      = 1'b0;
        div[15:8] = 8'd2;
        for (int c = 136; c <= 145; c++) begin
            ce1_e = (c == 137) || (c == 139) || (c == 141) || (c == 143) || (c == 145);
            ce0_e = (c % 3) == 1;
            cyc("div_change", {ce1_e, ce0_e, 1'b0, 1'b1, 1'b0}, M_ALL);
        end
        div[15:8] = 8'd0;
        for (int c = 146; c <= 150; c++) begin
            ce0_e = (c % 3) == 1;
            cyc("div_zero", {1'b1, ce0_e, 1'b0, 1'b1, 1'b0}, M_ALL);
        end

        locked = 1'b0;
        cyc("loss_e1", 5'b11010, M_ALL);
        cyc("loss_e2", 5'b10010, M_ALL);
        for (int k = 0; k < 5; k++) cyc("loss_e3", 5'b00101, M_ALL);

        locked = 1'b1;
        measure_ready(n);
        chk_int("relock_latency", n, 26);
        chk("relock_lost_sticky", outs(), 5'b00011, M_CTL);
        clr_lost = 1'b1;
        cyc("clr_lost", 5'b00000, M_LL);
        clr_lost = 1'b0;

        locked = 1'b0;
        cyc("loss2_e1", 5'b00010, M_CTL);
        cyc("loss2_e2", 5'b00010, M_CTL);
        clr_lost = 1'b1;
        cyc("loss2_set_wins", 5'b00101, M_ALL);
        clr_lost = 1'b0;
        cyc("loss2_sticky", 5'b00101, M_ALL);
        clr_lost = 1'b1;
        cyc("loss2_clear", 5'b00100, M_ALL);
        clr_lost = 1'b0;
        repeat (3) cyc("wait_lock", 5'b00100, M_ALL);

        // One low sample at edge 12 (filter count 10) pushes ready from 26 to 38.
        for (int k = 1; k <= 45; k++) begin
            locked = (k != 12);
            cyc("lock_glitch", {2'b00, (k < 38), (k >= 38), 1'b0}, M_CTL);
        end

        @(posedge clk);
        #2;
        chk("pre_async_rst", outs(), 5'b10010, 5'b10111);
        rst = 1'b1;
        #1;
        chk("async_rst", outs(), 5'b00100, M_ALL);
        @(negedge clk);
        rst = 1'b0;
        measure_ready(n);
        chk_int("post_rst_latency", n, 26);
        chk("post_rst_run", outs(), 5'b10010, 5'b10111);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
